tdm_mux4: RTL and testbench
===========================

TDM_MUX4 -- requirements
Module: tdm_mux4

Interface
REQ-001 SHALL have parameter: WIDTH, 8, data width of every channel and the output.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in_data  input  4*WIDTH  channel k data in bits [k*WIDTH +: WIDTH].
REQ-005 SHALL have port: in_valid  input  4  channel k offers a beat.
REQ-006 SHALL have port: in_last  input  4  channel k beat is the final beat of a packet.
REQ-007 SHALL have port: in_ready  output  4  channel k beat accepted this cycle (at most one bit set).
REQ-008 SHALL have port: out_data  output  WIDTH  registered output beat.
REQ-009 SHALL have port: out_sel  output  2  index of the source channel of out_data.
REQ-010 SHALL have port: out_last  output  1  last flag of the output beat.
REQ-011 SHALL have port: out_valid  output  1  output register holds a beat.
REQ-012 SHALL have port: out_ready  input  1  downstream accepts the beat.

Function
REQ-013 SHALL hold exactly one beat in an output register (out_data, out_sel, out_last, out_valid).
REQ-014 SHALL assert load_en when out_valid=0, or when out_valid=1 and out_ready=1, giving 1 beat/cycle throughput.
REQ-015 SHALL accept an input beat (in_ready[k]=1) only when load_en=1, in_valid[k]=1 and k is granted; in_ready is combinational and never depends on a later-cycle event.
REQ-016 SHALL load the accepted beat into the output register on the same edge; latency from input handshake to out_valid=1 is 1 cycle.
REQ-017 SHALL clear out_valid on an edge where out_valid=1, out_ready=1 and no new beat is accepted.
REQ-018 SHALL keep out_data, out_sel, out_last stable while out_valid=1 and out_ready=0.
REQ-019 SHALL implement a 2-state FSM: ARB and LOCK, with a 2-bit round-robin pointer ptr and a 2-bit locked channel lch.
REQ-020 In ARB SHALL grant the first k with in_valid[k]=1 searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-021 In ARB, on accepting a beat from k with in_last[k]=0, SHALL go to LOCK with lch=k.
REQ-022 In ARB, on accepting a beat from k with in_last[k]=1, SHALL stay in ARB and set ptr=k+1 mod 4 (3 wraps to 0).
REQ-023 In LOCK SHALL grant only lch; other channels' in_valid are ignored and their in_ready=0.
REQ-024 In LOCK, on accepting a beat from lch with in_last=1, SHALL return to ARB with ptr=lch+1 mod 4.
REQ-025 SHALL leave ptr and state unchanged on any cycle with no accepted beat (no valid inputs, or output stalled).
REQ-026 SHALL treat in_last of a single-beat packet in ARB as both first and last (no LOCK entry).

Reset
REQ-027 On rst=1 at a clock edge SHALL set out_valid=0, out_data=0, out_sel=0, out_last=0, state=ARB, ptr=0, lch=0.
REQ-028 While rst=1 SHALL drive in_ready=0 on all channels regardless of in_valid.
REQ-029 Reset asserted mid-packet (LOCK) SHALL discard the held beat and return to ARB; first grant after reset obeys ptr=0.

Verification
REQ-030 Reset then in_valid=4'b1111, all in_last=1, out_ready=1 held -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_valid=1 from cycle 1 after first accept.
REQ-031 Channel 2 sends 3 beats (last on third) while channels 0,1,3 valid -> out_sel=2,2,2 contiguous, then grant goes to 3, then 0.
REQ-032 out_valid=1, out_ready=0 for 5 cycles with all in_valid=1 -> in_ready=4'b0000, out_data/out_sel unchanged for all 5 cycles; first cycle out_ready=1 accepts next channel with no bubble.
REQ-033 Only channel 3 valid, single-beat packets -> ptr wraps to 0; next beat from channel 0 valid simultaneously with 3 -> channel 0 granted first.
REQ-034 rst=1 while LOCK on channel 1 after 1 beat -> next cycle out_valid=0, state=ARB; with channels 1 and 0 valid after reset, channel 0 granted.
REQ-035 No in_valid for 10 cycles, out_ready=1 -> out_valid=0 throughout, ptr unchanged (checked by next grant order).

Source files
------------

// File: rtl/tdm_mux4.sv
// Four-channel packet-aware TDM multiplexer: round-robin arbitration between packets,
// channel locked until its last beat, single registered output stage.
module tdm_mux4 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4*WIDTH-1:0] in_data,
  input  logic [3:0]         in_valid,
  input  logic [3:0]         in_last,
  output logic [3:0]         in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel,
  output logic               out_last,
  output logic               out_valid,
  input  logic               out_ready
);

  typedef enum logic {ARB, LOCK} state_t;

  state_t           r_state;
  logic [1:0]       r_ptr;
  logic [1:0]       r_lch;
  logic [WIDTH-1:0] r_data;
  logic [1:0]       r_sel;
  logic             r_last;
  logic             r_valid;

  logic             w_load_en;
  logic             w_gnt_vld;
  logic [1:0]       w_gnt_idx;
  logic             w_accept;
  logic             w_gnt_last;

  assign w_load_en = !r_valid || out_ready;

  // ARB searches ptr, ptr+1, ... (mod 4); LOCK only ever considers the locked channel.
  always_comb begin
    logic [1:0] w_cand;
    w_cand    = '0;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    if (r_state == LOCK) begin
      w_gnt_idx = r_lch;
      w_gnt_vld = in_valid[r_lch];
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        w_cand = r_ptr + 2'(i);
        if (!w_gnt_vld && in_valid[w_cand]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = w_cand;
        end
      end
    end
  end

  assign w_accept   = w_load_en && w_gnt_vld && !rst;
  assign w_gnt_last = in_last[w_gnt_idx];

  always_comb begin
    in_ready = '0;
    if (w_accept) in_ready[w_gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB;
      r_ptr   <= '0;
      r_lch   <= '0;
      r_data  <= '0;
      r_sel   <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_data  <= in_data[w_gnt_idx*WIDTH +: WIDTH];
      r_sel   <= w_gnt_idx;
      r_last  <= w_gnt_last;
      r_valid <= 1'b1;
      if (w_gnt_last) begin
        r_state <= ARB;
        r_ptr   <= w_gnt_idx + 2'd1;
      end else begin
        r_state <= LOCK;
        r_lch   <= w_gnt_idx;
      end
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_data  = r_data;
  assign out_sel   = r_sel;
  assign out_last  = r_last;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_tdm_mux4.sv
// Directed bench for tdm_mux4: vector table of {inputs, expected handshake/output}
// plus hand sequences for idle hold and mid-packet reset.
module tb_tdm_mux4;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_valid;
  logic [3:0]     in_last;
  logic [3:0]     in_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_last;
  logic           out_valid;
  logic           out_ready;

  tdm_mux4 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] v;
    logic [3:0] l;
    logic       ordy;
    logic [3:0] rdy;
    logic       ov;
    logic [1:0] sel;
    logic       ol;
  } vec_t;

  vec_t       tbl[$];
  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_dat;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] v, input logic [3:0] l, input logic o,
                     input logic [3:0] rdy, input logic ov, input logic [1:0] sel, input logic ol);
    vec_t e;
    e.v = v; e.l = l; e.ordy = o; e.rdy = rdy; e.ov = ov; e.sel = sel; e.ol = ol;
    tbl.push_back(e);
  endtask

  // Channel k carries {tag, k} so a reload from the wrong beat or channel is visible.
  task automatic drive(input logic [5:0] tag, input logic [3:0] v, input logic [3:0] l, input logic o);
    for (int k = 0; k < 4; k++) in_data[k*W +: W] = {tag, 2'(k)};
    in_valid  = v;
    in_last   = l;
    out_ready = o;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(6'h3f, 4'b1111, 4'b1111, 1'b1);
    #1;
    chk("rst_in_ready", 0, 32'(in_ready), 32'h0);
    cyc();
    cyc();
    chk("rst_in_ready", 1, 32'(in_ready), 32'h0);
    chk("rst_out_valid", 0, 32'(out_valid), 32'h0);
    chk("rst_out_data", 0, 32'(out_data), 32'h0);
    chk("rst_out_sel", 0, 32'(out_sel), 32'h0);
    chk("rst_out_last", 0, 32'(out_last), 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(6'h0, 4'b0, 4'b0, 1'b0);
    exp_dat = '0;

    // v, l, ordy | exp in_ready, out_valid, out_sel, out_last (after the edge)
    add(4'b1111, 4'b1111, 1, 4'b0001, 1, 2'd0, 1); // round robin from ptr=0
    add(4'b1111, 4'b1111, 1, 4'b0010, 1, 2'd1, 1);
    add(4'b1111, 4'b1111, 1, 4'b0100, 1, 2'd2, 1);
    add(4'b1111, 4'b1111, 1, 4'b1000, 1, 2'd3, 1);
    add(4'b1111, 4'b1111, 1, 4'b0001, 1, 2'd0, 1); // ptr -> 1
    add(4'b0010, 4'b1111, 1, 4'b0010, 1, 2'd1, 1); // ptr -> 2
    add(4'b1111, 4'b1011, 1, 4'b0100, 1, 2'd2, 0); // ch2 first beat, lock
    add(4'b1011, 4'b1111, 1, 4'b0000, 0, 2'd2, 0); // locked ch2 idle: others ignored
    add(4'b1111, 4'b1011, 1, 4'b0100, 1, 2'd2, 0);
    add(4'b1111, 4'b1111, 1, 4'b0100, 1, 2'd2, 1); // ch2 last, ptr -> 3
    add(4'b1111, 4'b1111, 1, 4'b1000, 1, 2'd3, 1);
    add(4'b1111, 4'b1111, 1, 4'b0001, 1, 2'd0, 1); // ptr -> 1
    for (int i = 0; i < 5; i++)
      add(4'b1111, 4'b1111, 0, 4'b0000, 1, 2'd0, 1); // stall holds beat
    add(4'b1111, 4'b1111, 1, 4'b0010, 1, 2'd1, 1); // no bubble on release, ptr -> 2
    add(4'b1000, 4'b1111, 1, 4'b1000, 1, 2'd3, 1); // ch3 single beat, ptr wraps to 0
    add(4'b1001, 4'b1111, 1, 4'b0001, 1, 2'd0, 1); // ch0 beats ch3, ptr -> 1
    add(4'b0000, 4'b1111, 1, 4'b0000, 0, 2'd0, 1); // drain
    add(4'b0100, 4'b1111, 0, 4'b0100, 1, 2'd2, 1); // empty register loads despite !out_ready
    add(4'b1111, 4'b1111, 0, 4'b0000, 1, 2'd2, 1);
    add(4'b0000, 4'b1111, 1, 4'b0000, 0, 2'd2, 1); // ptr = 3

    cyc();
    do_reset();

    for (int r = 0; r < tbl.size(); r++) begin
      drive(6'(r), tbl[r].v, tbl[r].l, tbl[r].ordy);
      #1;
      chk("in_ready", r, 32'(in_ready), 32'(tbl[r].rdy));
      if (tbl[r].rdy != 4'b0000) exp_dat = {6'(r), tbl[r].sel};
      cyc();
      chk("out_valid", r, 32'(out_valid), 32'(tbl[r].ov));
      if (tbl[r].ov) begin
        chk("out_sel", r, 32'(out_sel), 32'(tbl[r].sel));
        chk("out_last", r, 32'(out_last), 32'(tbl[r].ol));
        chk("out_data", r, 32'(out_data), 32'(exp_dat));
      end
    end

    // Idle for 10 cycles: nothing emitted and ptr (3) retained.
    for (int i = 0; i < 10; i++) begin
      drive(6'h20, 4'b0000, 4'b1111, 1'b1);
      cyc();
      chk("idle_out_valid", i, 32'(out_valid), 32'h0);
    end
    drive(6'h21, 4'b1111, 4'b1111, 1'b1);
    #1;
    chk("idle_next_grant", 0, 32'(in_ready), 32'h8);
    cyc();
    chk("idle_next_sel", 0, 32'(out_sel), 32'h3);
    chk("idle_next_data", 0, 32'(out_data), 32'h87);

    // Reset while locked on channel 1 after its first beat.
    do_reset();
    drive(6'h22, 4'b0010, 4'b0000, 1'b1);
    #1;
    chk("lock1_grant", 0, 32'(in_ready), 32'h2);
    cyc();
    chk("lock1_sel", 0, 32'(out_sel), 32'h1);
    chk("lock1_valid", 0, 32'(out_valid), 32'h1);
    rst = 1'b1;
    drive(6'h23, 4'b0011, 4'b0000, 1'b1);
    #1;
    chk("midrst_in_ready", 0, 32'(in_ready), 32'h0);
    cyc();
    chk("midrst_out_valid", 0, 32'(out_valid), 32'h0);
    chk("midrst_out_data", 0, 32'(out_data), 32'h0);
    rst = 1'b0;
    drive(6'h24, 4'b0011, 4'b0011, 1'b1);
    #1;
    chk("post_rst_grant", 0, 32'(in_ready), 32'h1);
    cyc();
    chk("post_rst_sel", 0, 32'(out_sel), 32'h0);
    chk("post_rst_data", 0, 32'(out_data), 32'h90);
    chk("post_rst_valid", 0, 32'(out_valid), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule
